// File: rtl/viterbi_pkg.sv
// Shared definitions for the K=4, rate-1/2 hard-decision Viterbi decoder.
// Holds the encoder generators, trellis size, the initial metric for the
// states that cannot be the start state, and the encoder output function
// used by both the decoder and the bench's encoder model.
package viterbi_pkg;

  localparam logic [3:0] G1          = 4'b1111;
  localparam logic [3:0] G0          = 4'b1011;
  localparam int         NSTATES     = 8;
  localparam int         PM_INIT_BAD = 8;

  // Encoder output for state {s2,s1,s0} (s0 newest) and input d.
  // The generator LSB taps d, so the tap register is {s2,s1,s0,d}:
  // G1 gives d^s0^s1^s2 and G0 gives d^s0^s2.
  function automatic logic [1:0] exp_sym(input logic [2:0] state, input logic d);
    logic [3:0] taps;
    taps    = {state, d};
    exp_sym = {^(taps & G1), ^(taps & G0)};
  endfunction

  // Number of set bits in a 2-bit word (Hamming weight, 0..2).
  function automatic logic [1:0] hamming2(input logic [1:0] v);
    hamming2 = {v[1] & v[0], v[1] ^ v[0]};
  endfunction

endpackage

// File: rtl/viterbi_decoder_k4_acs.sv
// Add-compare-select for one trellis state.
// Ports:
//   pm_a, pm_b  path metrics of the predecessors with x=0 / x=1
//   bm_a, bm_b  branch metrics of the two incoming branches
//   pm_sel      surviving candidate, clamped at 2^PM_W-1
//   sel         1 when the x=1 predecessor wins (ties keep x=0)
module viterbi_acs #(
  parameter int PM_W = 6
) (
  input  logic [PM_W-1:0] pm_a,
  input  logic [PM_W-1:0] pm_b,
  input  logic [1:0]      bm_a,
  input  logic [1:0]      bm_b,
  output logic [PM_W-1:0] pm_sel,
  output logic            sel
);

  logic [PM_W:0] cand_a_s;
  logic [PM_W:0] cand_b_s;
  logic [PM_W:0] cand_min_s;

  // Compare the two extended candidates and clamp the winner instead of wrapping
  always_comb begin
    cand_a_s   = {1'b0, pm_a} + {{(PM_W-1){1'b0}}, bm_a};
    cand_b_s   = {1'b0, pm_b} + {{(PM_W-1){1'b0}}, bm_b};
    sel        = (cand_b_s < cand_a_s);
    cand_min_s = sel ? cand_b_s : cand_a_s;
    pm_sel     = cand_min_s[PM_W] ? {PM_W{1'b1}} : cand_min_s[PM_W-1:0];
  end

endmodule

// File: rtl/viterbi_decoder_k4.sv
// Hard-decision Viterbi decoder for the rate-1/2, K=4 code (1111 / 1011)
// using register-exchange survivors of TB_DEPTH decisions.
// Ports:
//   clk          rising-edge clock
//   reset        synchronous, active-low reset (priority over sym_valid)
//   sym_valid    a new code symbol is present on sym
//   sym          code symbol, [1] = G1 bit, [0] = G0 bit
//   bit_out      decoded data bit (held between updates)
//   bit_valid    one-cycle pulse qualifying bit_out
//   best_metric  accumulated distance of the winning path, saturating
module viterbi_decoder_k4 #(
  parameter int TB_DEPTH = 16,
  parameter int PM_W     = 6
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            sym_valid,
  input  logic [1:0]      sym,
  output logic            bit_out,
  output logic            bit_valid,
  output logic [PM_W-1:0] best_metric
);
  import viterbi_pkg::*;

  localparam int            CNT_W   = $clog2(TB_DEPTH);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TB_DEPTH - 1);

  logic [PM_W-1:0]     pm_r       [NSTATES];
  logic [TB_DEPTH-1:0] surv_r     [NSTATES];
  logic [CNT_W-1:0]    fill_r;

  logic [1:0]          bm0_s      [NSTATES];
  logic [1:0]          bm1_s      [NSTATES];
  logic [PM_W-1:0]     pm_sel_s   [NSTATES];
  logic                sel_s      [NSTATES];
  logic [TB_DEPTH-1:0] surv_new_s [NSTATES];
  logic [PM_W-1:0]     pm_new_s   [NSTATES];
  logic [2:0]          best_s;
  logic [PM_W-1:0]     min_s;
  logic [PM_W:0]       metric_sum_s;
  logic [PM_W-1:0]     metric_next_s;

  // Next state n={n2,n1,n0} is reached from {x,n2,n1} with input bit n0.
  for (genvar n = 0; n < NSTATES; n++) begin : g_state
    localparam int   P0 = n / 2;
    localparam int   P1 = n / 2 + NSTATES / 2;
    localparam logic D  = 1'(n % 2);

    assign bm0_s[n] = hamming2(sym ^ exp_sym(3'(P0), D));
    assign bm1_s[n] = hamming2(sym ^ exp_sym(3'(P1), D));

    viterbi_acs #(.PM_W(PM_W)) u_acs (
      .pm_a   (pm_r[P0]),
      .pm_b   (pm_r[P1]),
      .bm_a   (bm0_s[n]),
      .bm_b   (bm1_s[n]),
      .pm_sel (pm_sel_s[n]),
      .sel    (sel_s[n])
    );

    assign surv_new_s[n] = sel_s[n] ? {surv_r[P1][TB_DEPTH-2:0], D}
                                    : {surv_r[P0][TB_DEPTH-2:0], D};
  end

  // Find the lowest-index minimum, normalise metrics and accumulate the winner's distance
  always_comb begin
    best_s = 3'd0;
    for (int i = 1; i < NSTATES; i++) begin
      best_s = (pm_sel_s[i] < pm_sel_s[best_s]) ? 3'(i) : best_s;
    end
    min_s = pm_sel_s[best_s];
    for (int i = 0; i < NSTATES; i++) begin
      pm_new_s[i] = pm_sel_s[i] - min_s;
    end
    metric_sum_s  = {1'b0, best_metric} + {1'b0, min_s};
    metric_next_s = metric_sum_s[PM_W] ? {PM_W{1'b1}} : metric_sum_s[PM_W-1:0];
  end

  // Trellis state, survivors, fill count and registered outputs
  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int i = 0; i < NSTATES; i++) begin
        pm_r[i]   <= (i == 0) ? {PM_W{1'b0}} : PM_W'(PM_INIT_BAD);
        surv_r[i] <= {TB_DEPTH{1'b0}};
      end
      fill_r      <= {CNT_W{1'b0}};
      bit_out     <= 1'b0;
      bit_valid   <= 1'b0;
      best_metric <= {PM_W{1'b0}};
    end else if (sym_valid) begin
      for (int i = 0; i < NSTATES; i++) begin
        pm_r[i]   <= pm_new_s[i];
        surv_r[i] <= surv_new_s[i];
      end
      fill_r      <= (fill_r == CNT_MAX) ? fill_r : fill_r + CNT_W'(1);
      bit_out     <= surv_new_s[best_s][TB_DEPTH-1];
      bit_valid   <= (fill_r == CNT_MAX);
      best_metric <= metric_next_s;
    end else begin
      bit_valid   <= 1'b0;
    end
  end

endmodule

// File: tb/tb_viterbi_decoder_k4.sv
// Directed bench for viterbi_decoder_k4: zero stream, impulse, single
// error, idle gaps, mid-stream reset and a random encoded loopback.
module tb_viterbi_decoder_k4;
  import viterbi_pkg::*;

  localparam int TB_DEPTH = 16;
  localparam int PM_W     = 6;

  logic            clk;
  logic            reset;
  logic            sym_valid;
  logic [1:0]      sym;
  logic            bit_out;
  logic            bit_valid;
  logic [PM_W-1:0] best_metric;

  int n_cmp;
  int n_mis;
  int nacc;
  int first_valid;
  logic prev_out;
  logic got_q[$];
  logic [1:0] imp [4];

  viterbi_decoder_k4 #(.TB_DEPTH(TB_DEPTH), .PM_W(PM_W)) dut (
    .clk         (clk),
    .reset       (reset),
    .sym_valid   (sym_valid),
    .sym         (sym),
    .bit_out     (bit_out),
    .bit_valid   (bit_valid),
    .best_metric (best_metric)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input int got, input int exp);
    n_cmp++;
    if (got != exp) begin
      n_mis++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // One clock: drive on the falling edge, sample 1 time unit after the rising edge.
  task automatic send(input logic v, input logic [1:0] s);
    @(negedge clk);
    sym_valid = v;
    sym       = s;
    @(posedge clk);
    #1;
    if (v) nacc++;
    check("bit_valid", int'(bit_valid), (v && nacc >= TB_DEPTH) ? 1 : 0);
    if (!v) check("bit_out_hold", int'(bit_out), int'(prev_out));
    if (bit_valid) begin
      got_q.push_back(bit_out);
      if (first_valid < 0) first_valid = nacc;
    end
    prev_out = bit_out;
  endtask

  // Reset for one cycle with sym_valid asserted to exercise reset priority.
  task automatic do_reset();
    @(negedge clk);
    reset     = 1'b0;
    sym_valid = 1'b1;
    sym       = 2'($urandom);
    @(posedge clk);
    #1;
    check("rst_bit_valid", int'(bit_valid), 0);
    check("rst_bit_out", int'(bit_out), 0);
    check("rst_best_metric", int'(best_metric), 0);
    reset       = 1'b1;
    sym_valid   = 1'b0;
    nacc        = 0;
    first_valid = -1;
    prev_out    = 1'b0;
    got_q.delete();
  endtask

  // 40-symbol stream: impulse head (optionally with symbol 2 corrupted) then zeros.
  task automatic run_impulse(input logic corrupt, input logic gaps);
    logic [1:0] s;
    for (int i = 0; i < 40; i++) begin
      s = (i < 4) ? imp[i] : 2'b00;
      if (corrupt && i == 2) s = 2'b00;
      if (gaps && i > 0) begin
        repeat ($urandom_range(1, 3)) send(1'b0, 2'($urandom));
      end
      send(1'b1, s);
    end
  endtask

  task automatic check_impulse(input string pfx, input int exp_metric);
    int ones;
    ones = 0;
    check({pfx, "_first_valid"}, first_valid, TB_DEPTH);
    check({pfx, "_nbits"}, got_q.size(), 25);
    if (got_q.size() > 0) check({pfx, "_bit0"}, int'(got_q[0]), 1);
    for (int i = 1; i < got_q.size(); i++) ones += int'(got_q[i]);
    check({pfx, "_tail_ones"}, ones, 0);
    check({pfx, "_best_metric"}, int'(best_metric), exp_metric);
  endtask

  initial begin
    int ones;
    int mism;
    int last_err;
    logic d;
    logic [1:0] c;
    logic [2:0] st;
    logic src_q[$];

    n_cmp       = 0;
    n_mis       = 0;
    nacc        = 0;
    first_valid = -1;
    prev_out    = 1'b0;
    reset       = 1'b0;
    sym_valid   = 1'b0;
    sym         = 2'b00;
    imp[0] = 2'b11; imp[1] = 2'b11; imp[2] = 2'b10; imp[3] = 2'b11;

    // T1: all-zero stream
    do_reset();
    for (int i = 0; i < 40; i++) send(1'b1, 2'b00);
    ones = 0;
    foreach (got_q[i]) ones += int'(got_q[i]);
    check("t1_first_valid", first_valid, TB_DEPTH);
    check("t1_nbits", got_q.size(), 25);
    check("t1_ones", ones, 0);
    check("t1_best_metric", int'(best_metric), 0);

    // T2: impulse response of the encoder
    do_reset();
    run_impulse(1'b0, 1'b0);
    check_impulse("t2", 0);

    // T3: impulse with one channel bit error
    do_reset();
    run_impulse(1'b1, 1'b0);
    check_impulse("t3", 1);

    // T4: impulse with idle gaps between symbols
    do_reset();
    run_impulse(1'b0, 1'b1);
    check_impulse("t4", 0);

    // T5: random symbols, reset mid-stream, then a clean zero stream
    do_reset();
    for (int i = 0; i < 20; i++) send(1'b1, 2'($urandom));
    do_reset();
    for (int i = 0; i < 30; i++) send(1'b1, 2'b00);
    ones = 0;
    foreach (got_q[i]) ones += int'(got_q[i]);
    check("t5_first_valid", first_valid, TB_DEPTH);
    check("t5_nbits", got_q.size(), 15);
    check("t5_ones", ones, 0);
    check("t5_best_metric", int'(best_metric), 0);

    // T6: random data through the encoder model with sparse single-bit errors
    do_reset();
    st       = 3'd0;
    last_err = -100;
    for (int i = 0; i < 2000; i++) begin
      d = 1'($urandom);
      src_q.push_back(d);
      c  = exp_sym(st, d);
      st = {st[1:0], d};
      if ((i - last_err) >= 10 && i < 1980 && $urandom_range(0, 1) == 1) begin
        c        = c ^ (($urandom_range(0, 1) == 1) ? 2'b10 : 2'b01);
        last_err = i;
      end
      send(1'b1, c);
    end
    mism = 0;
    foreach (got_q[i]) begin
      if (got_q[i] != src_q[i]) mism++;
    end
    check("t6_nbits", got_q.size(), 2000 - (TB_DEPTH - 1));
    check("t6_bit_mismatches", mism, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
